game_board: RTL and testbench
=============================

# game_board

Board-state store and win/draw detector on the responder side of the game controller's cell-write interface. Accepts one cell write (address plus cell state) from the controller, updates the 9-cell board, and scans the 8 win lines sequentially, one per cycle. Reports game completion and the winner back to the controller on `gameIsDone`. Sits between the game controller and the display/board-readout logic.

## Interface

No parameters. Cell codes are fixed by the shared package: EMPTY = 2'b00, X = 2'b10, O = 2'b11.

- `ph1`  in  1  two-phase clock, phase 1
- `ph2`  in  1  two-phase clock, phase 2
- `reset`  in  1  reset, synchronous, active-low
- `write`  in  1  write strobe from the controller; one cycle = one move
- `addr`  in  4  cell index 0..8, row-major (0 = top-left, 8 = bottom-right)
- `cellState`  in  2  value to write: X or O
- `board`  out  18  packed board; cell i is at `board[2i+1:2i]`
- `busy`  out  1  high while the line scan is in progress
- `gameIsDone`  out  1  high from win/draw detection until reset
- `winner`  out  2  winning cell code; EMPTY on draw or while not done
- `writeError`  out  1  one-cycle pulse for a rejected write

## Operation

- FSM states:
  - IDLE: accepting moves.
  - SCAN: line counter 0..7, checking one win line per cycle.
  - DONE: game over; terminal until reset.
- IDLE, accepted write: requires `write`=1, `addr` ≤ 8, `cellState` ∈ {X, O}, and the target cell EMPTY.
  - Store the cell, clear the line counter, go to SCAN.
- IDLE, rejected write (occupied cell, `addr` ≥ 9, or `cellState` ∈ {00, 01}):
  - Board is unchanged and the FSM stays in IDLE.
  - `writeError` pulses for one cycle.
- Write in SCAN or DONE: ignored and `writeError` pulses. The controller must hold off while `busy` or `gameIsDone` is high.
- SCAN, line order by counter index:
  - 0 → cells {0,1,2}, 1 → {3,4,5}, 2 → {6,7,8}
  - 3 → {0,3,6}, 4 → {1,4,7}, 5 → {2,5,8}
  - 6 → {0,4,8}, 7 → {2,4,6}
- A line matches when all three cells are equal and non-EMPTY.
  - On a match: go to DONE, set `winner` to that cell code, set `gameIsDone`=1. The remaining lines are not checked.
- Counter reaches 7 with no match:
  - If all 9 cells are non-EMPTY: draw. Go to DONE with `winner`=EMPTY and `gameIsDone`=1.
  - Otherwise return to IDLE.
- Both players are checked on every scan, so no move-parity knowledge is needed. Alternation of X and O is the controller's responsibility and is not checked here.

## Timing

- All state updates on the rising edge of `ph1`. Inputs are sampled with `ph1` and must be stable through the `ph1` high phase (driven after the `ph2` rising edge). Outputs are registered and valid from `ph1` falling through the next `ph1` rising edge.
- Reset values, applied when `reset`=0 at a `ph1` edge:
  - `board`=0 (all EMPTY), FSM in IDLE, counter=0.
  - `busy`=0, `gameIsDone`=0, `winner`=EMPTY, `writeError`=0.
- Accepted write sampled at edge k:
  - `board` shows the new cell after edge k.
  - `busy`=1 from edge k through the edge that ends the scan.
- Line j is evaluated at edge k+1+j. On a match, `gameIsDone` and `winner` are valid after edge k+1+j.
- With no match, `busy` falls after edge k+8, at which point the FSM is in IDLE or DONE (draw). Worst-case scan latency is 8 cycles.
- `writeError` is high for exactly the cycle after the offending sampled edge.
- Reset mid-scan or in DONE: reset has priority over everything. Board is cleared and all outputs take their reset values on that edge.
- Write and reset in the same cycle: reset wins and no write occurs.

## Structure

- Shared package `game_pkg`:
  - `cellStateType` enum: EMPTY/X/O, values as above.
  - `boardStateType` enum: IDLE/SCAN/DONE.
  - Constant `WIN_LINES[8][3]`: 4-bit cell indices in the scan order above.
  - `NUM_CELLS` = 9.
- One sub-module, `line_checker`: combinational.
  - Inputs: three 2-bit cells.
  - Outputs: `match` and the 2-bit matched code.
  - Instantiated once and fed by a mux indexed by the line counter.
- Top-level logic: the FSM, the 18-bit board register, the 3-bit line counter, the write-validation logic, and the full-board detect (all 9 cells non-EMPTY).

## Test plan

- Reset, then idle for 10 cycles → `board`=18'h0, `busy`=0, `gameIsDone`=0, `winner`=00, `writeError`=0 throughout.
- Write X at addr 4 → `board[9:8]`=10, `busy` high for exactly 8 cycles, then FSM in IDLE with `gameIsDone`=0.
- Moves X0, O3, X1, O4, X2, each issued after `busy` falls → on the last move `gameIsDone`=1 and `winner`=10 one cycle after the write (line 0); later writes pulse `writeError`.
- Moves ending with O on cells 2, 4, 6 → win found on line 7; `gameIsDone` asserted 8 cycles after the final write; `winner`=11.
- Full board with no line, e.g. X0 O1 X2 X3 O4 X5 O6 X7 O8 → draw; `gameIsDone`=1, `winner`=00.
- Error and reset cases, each checked for `writeError` pulsing with `board` unchanged:
  - write to an occupied cell
  - write to `addr`=9
  - write with `cellState`=01
  - write while `busy`=1
- Then assert `reset`=0 mid-scan → all outputs return to reset values on the next `ph1` edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared cell codes, FSM states and the win-line table for the game board.
package game_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        X     = 2'b10,
        O     = 2'b11
    } cellStateType;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } boardStateType;

    localparam int NUM_CELLS = 9;

    // Cell indices of each win line, in the order the scan visits them:
    // three rows, three columns, then the two diagonals.
    localparam logic [3:0] WIN_LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

endpackage

// File: rtl/game_board_line_checker.sv
// Combinational check of one win line: three equal, non-empty cells.
module line_checker
    import game_pkg::*;
(
    input  logic [1:0] cell_a,
    input  logic [1:0] cell_b,
    input  logic [1:0] cell_c,
    output logic       match,
    output logic [1:0] code
);

    // A line matches only when all three cells hold the same player's mark.
    always_comb begin
        match = (cell_a != EMPTY) && (cell_a == cell_b) && (cell_b == cell_c);
        code  = match ? cell_a : EMPTY;
    end

endmodule

// File: rtl/game_board.sv
// Board store with sequential win/draw scan; one win line checked per ph1 cycle.
module game_board
    import game_pkg::*;
(
    input  logic        ph1,
    input  logic        ph2,
    input  logic        reset,
    input  logic        write,
    input  logic [3:0]  addr,
    input  logic [1:0]  cellState,
    output logic [17:0] board,
    output logic        busy,
    output logic        gameIsDone,
    output logic [1:0]  winner,
    output logic        writeError
);

    logic [17:0]   board_q, board_d;
    boardStateType state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [1:0]    winner_q, winner_d;
    logic          err_q, err_d;

    logic [1:0]    cells [NUM_CELLS];
    logic [1:0]    line_cell [3];
    logic [1:0]    addr_cell;
    logic          addr_ok;
    logic          state_ok;
    logic          write_ok;
    logic          board_full;
    logic          line_match;
    logic [1:0]    line_code;

    // ph2 only governs when the controller drives inputs; nothing here runs on it.
    logic          unused_ph2;
    assign unused_ph2 = ph2;

    // Unpack the board and detect a completely filled board.
    always_comb begin
        board_full = 1'b1;
        for (int i = 0; i < NUM_CELLS; i++) begin
            cells[i] = board_q[2*i +: 2];
            if (board_q[2*i +: 2] == EMPTY) begin
                board_full = 1'b0;
            end
        end
    end

    // Select the three cells of the line addressed by the scan counter.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            line_cell[p] = EMPTY;
            for (int i = 0; i < NUM_CELLS; i++) begin
                if (WIN_LINES[cnt_q][p] == 4'(i)) begin
                    line_cell[p] = cells[i];
                end
            end
        end
    end

    line_checker u_line_checker (
        .cell_a (line_cell[0]),
        .cell_b (line_cell[1]),
        .cell_c (line_cell[2]),
        .match  (line_match),
        .code   (line_code)
    );

    // Validate an incoming move: legal address, legal mark, target cell empty.
    always_comb begin
        addr_cell = EMPTY;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (addr == 4'(i)) begin
                addr_cell = cells[i];
            end
        end
        addr_ok  = (addr < 4'(NUM_CELLS));
        state_ok = (cellState == X) || (cellState == O);
        write_ok = write && addr_ok && state_ok && (addr_cell == EMPTY);
    end

    // FSM next state: accept moves in IDLE, scan lines in SCAN, hold in DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        board_d  = board_q;
        winner_d = winner_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (write_ok) begin
                    for (int i = 0; i < NUM_CELLS; i++) begin
                        if (addr == 4'(i)) begin
                            board_d[2*i +: 2] = cellState;
                        end
                    end
                    cnt_d   = 3'd0;
                    state_d = SCAN;
                end else if (write) begin
                    err_d = 1'b1;
                end
            end
            SCAN: begin
                err_d = write;
                if (line_match) begin
                    state_d  = DONE;
                    winner_d = line_code;
                end else if (cnt_q == 3'd7) begin
                    // Last line checked with no winner: a full board is a draw.
                    state_d  = board_full ? DONE : IDLE;
                    winner_d = EMPTY;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                err_d = write;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset has priority over any write.
    always_ff @(posedge ph1) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            board_q  <= '0;
            winner_q <= EMPTY;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            board_q  <= board_d;
            winner_q <= winner_d;
            err_q    <= err_d;
        end
    end

    assign board      = board_q;
    assign busy       = (state_q == SCAN);
    assign gameIsDone = (state_q == DONE);
    assign winner     = winner_q;
    assign writeError = err_q;

endmodule

// File: tb/tb_game_board.sv
// Scoreboard bench for game_board: stimulus pushes hand-computed per-cycle
// expectations, a monitor on ph1 falling pops and compares them.
module tb_game_board;
    import game_pkg::*;

    logic        ph1;
    logic        ph2;
    logic        reset;
    logic        write;
    logic [3:0]  addr;
    logic [1:0]  cellState;
    logic [17:0] board;
    logic        busy;
    logic        gameIsDone;
    logic [1:0]  winner;
    logic        writeError;

    game_board dut (
        .ph1        (ph1),
        .ph2        (ph2),
        .reset      (reset),
        .write      (write),
        .addr       (addr),
        .cellState  (cellState),
        .board      (board),
        .busy       (busy),
        .gameIsDone (gameIsDone),
        .winner     (winner),
        .writeError (writeError)
    );

    // Non-overlapping two-phase clock, 20-unit period.
    initial begin
        ph1 = 1'b0;
        ph2 = 1'b0;
        forever begin
            #2 ph1 = 1'b1;
            #8 ph1 = 1'b0;
            #2 ph2 = 1'b1;
            #8 ph2 = 1'b0;
        end
    end

    typedef struct {
        logic [17:0] board;
        logic        busy;
        logic        done;
        logic [1:0]  winner;
        logic        err;
        int          tag;
        int          idx;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cur_tag  = 0;
    int   step_no  = 0;

    // Monitor: one expected snapshot per ph1 cycle, compared after the edge.
    always @(negedge ph1) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (board !== e.board || busy !== e.busy || gameIsDone !== e.done ||
                winner !== e.winner || writeError !== e.err) begin
                failures++;
                $display("FAIL test%0d step%0d: got board=%h busy=%b done=%b winner=%b err=%b, expected board=%h busy=%b done=%b winner=%b err=%b",
                         e.tag, e.idx, board, busy, gameIsDone, winner, writeError,
                         e.board, e.busy, e.done, e.winner, e.err);
            end
        end
    end

    task automatic step(input logic rst_n, input logic w, input logic [3:0] a,
                        input logic [1:0] cs, input logic [17:0] eb, input logic eby,
                        input logic ed, input logic [1:0] ew, input logic ee);
        exp_t e;
        @(posedge ph2);
        reset     = rst_n;
        write     = w;
        addr      = a;
        cellState = cs;
        e.board   = eb;
        e.busy    = eby;
        e.done    = ed;
        e.winner  = ew;
        e.err     = ee;
        e.tag     = cur_tag;
        e.idx     = step_no;
        step_no++;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 4'd0, EMPTY, 18'h0, 1'b0, 1'b0, EMPTY, 1'b0);
    endtask

    task automatic idle(input int n, input logic [17:0] eb, input logic ed, input logic [1:0] ew);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 4'd0, EMPTY, eb, 1'b0, ed, ew, 1'b0);
        end
    endtask

    // Accepted move: busy for scan_len cycles, then the given end state.
    task automatic move(input logic [3:0] a, input logic [1:0] cs, input logic [17:0] eb,
                        input int scan_len, input logic ed, input logic [1:0] ew);
        step(1'b1, 1'b1, a, cs, eb, 1'b1, 1'b0, EMPTY, 1'b0);
        for (int i = 1; i < scan_len; i++) begin
            step(1'b1, 1'b0, 4'd0, EMPTY, eb, 1'b1, 1'b0, EMPTY, 1'b0);
        end
        step(1'b1, 1'b0, 4'd0, EMPTY, eb, 1'b0, ed, ew, 1'b0);
    endtask

    // Rejected write while not scanning: one-cycle error pulse, board unchanged.
    task automatic reject(input logic [3:0] a, input logic [1:0] cs, input logic [17:0] eb,
                          input logic ed, input logic [1:0] ew);
        step(1'b1, 1'b1, a, cs, eb, 1'b0, ed, ew, 1'b1);
        step(1'b1, 1'b0, 4'd0, EMPTY, eb, 1'b0, ed, ew, 1'b0);
    endtask

    initial begin
        reset     = 1'b0;
        write     = 1'b0;
        addr      = 4'd0;
        cellState = EMPTY;

        // Reset and idle.
        cur_tag = 1;
        do_reset();
        do_reset();
        idle(10, 18'h0, 1'b0, EMPTY);

        // Single move, full 8-cycle scan, then input error cases.
        cur_tag = 2;
        move(4'd4, X, 18'h00200, 8, 1'b0, EMPTY);
        reject(4'd4, O,     18'h00200, 1'b0, EMPTY);
        reject(4'd9, X,     18'h00200, 1'b0, EMPTY);
        reject(4'd0, 2'b01, 18'h00200, 1'b0, EMPTY);
        reject(4'd0, EMPTY, 18'h00200, 1'b0, EMPTY);
        do_reset();

        // X wins on the top row, found on the first line scanned.
        cur_tag = 3;
        move(4'd0, X, 18'h00002, 8, 1'b0, EMPTY);
        move(4'd3, O, 18'h000C2, 8, 1'b0, EMPTY);
        move(4'd1, X, 18'h000CA, 8, 1'b0, EMPTY);
        move(4'd4, O, 18'h003CA, 8, 1'b0, EMPTY);
        move(4'd2, X, 18'h003EA, 1, 1'b1, X);
        reject(4'd5, O, 18'h003EA, 1'b1, X);
        idle(2, 18'h003EA, 1'b1, X);
        do_reset();

        // O wins on the anti-diagonal, the last line scanned.
        cur_tag = 4;
        move(4'd0, X, 18'h00002, 8, 1'b0, EMPTY);
        move(4'd2, O, 18'h00032, 8, 1'b0, EMPTY);
        move(4'd3, X, 18'h000B2, 8, 1'b0, EMPTY);
        move(4'd4, O, 18'h003B2, 8, 1'b0, EMPTY);
        move(4'd5, X, 18'h00BB2, 8, 1'b0, EMPTY);
        move(4'd6, O, 18'h03BB2, 8, 1'b1, O);
        idle(2, 18'h03BB2, 1'b1, O);
        do_reset();

        // Full board with no line: draw.
        cur_tag = 5;
        move(4'd0, X, 18'h00002, 8, 1'b0, EMPTY);
        move(4'd1, O, 18'h0000E, 8, 1'b0, EMPTY);
        move(4'd2, X, 18'h0002E, 8, 1'b0, EMPTY);
        move(4'd3, X, 18'h000AE, 8, 1'b0, EMPTY);
        move(4'd4, O, 18'h003AE, 8, 1'b0, EMPTY);
        move(4'd5, X, 18'h00BAE, 8, 1'b0, EMPTY);
        move(4'd6, O, 18'h03BAE, 8, 1'b0, EMPTY);
        move(4'd7, X, 18'h0BBAE, 8, 1'b0, EMPTY);
        move(4'd8, O, 18'h3BBAE, 8, 1'b1, EMPTY);
        reject(4'd0, X, 18'h3BBAE, 1'b1, EMPTY);
        do_reset();

        // Write while busy, then reset mid-scan, then reset together with a write.
        cur_tag = 6;
        step(1'b1, 1'b1, 4'd0, X, 18'h00002, 1'b1, 1'b0, EMPTY, 1'b0);
        step(1'b1, 1'b1, 4'd5, X, 18'h00002, 1'b1, 1'b0, EMPTY, 1'b1);
        step(1'b1, 1'b0, 4'd0, EMPTY, 18'h00002, 1'b1, 1'b0, EMPTY, 1'b0);
        do_reset();
        idle(2, 18'h0, 1'b0, EMPTY);
        step(1'b0, 1'b1, 4'd0, X, 18'h0, 1'b0, 1'b0, EMPTY, 1'b0);
        idle(2, 18'h0, 1'b0, EMPTY);

        // Drain: every pushed expectation must have been consumed.
        @(posedge ph2);
        write = 1'b0;
        @(posedge ph2);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
